// File: rtl/lw_sha_pkg.sv
// rtl/lw_sha_pkg.sv - shared types and helpers for the lightweight SHA/HMAC engine
//
// Purpose: state encoding, digest array size and digest length clamp used by
// the digest output stage.
// Ports: none (package).
package lw_sha_pkg;

  localparam int DIGEST_WORDS = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    ZERO   = 2'd2
  } digest_stream_state_e;

  // Out-of-range lengths (0 or above 8) fall back to the full digest.
  function automatic logic [3:0] digest_len_clamp(input logic [3:0] len);
    if (len == 4'd0 || len > 4'd8) begin
      return 4'd8;
    end
    return len;
  endfunction

endpackage

// File: rtl/lw_digest_stream.sv
// rtl/lw_digest_stream.sv - digest capture, truncation, streaming and zeroization
//
// Purpose: captures the eight-word digest on done_i, streams the first len
// words over a valid/ready interface with a last marker, then wipes the buffer.
// Ports:
//   clk_i, aresetn_i       clock, asynchronous active-low reset
//   hash_i[0..7]           digest words from the engine, word 0 sent first
//   done_i, digest_len_i   capture strobe and requested word count (1..8)
//   abort_i                wipe buffer and return to idle (highest priority)
//   clear_i                clear sticky overrun_o
//   dout_o/_valid_o/_last_o, dout_ready_i   output word stream
//   busy_o                 high while streaming or wiping
//   overrun_o              sticky: digest dropped because the stage was busy
module lw_digest_stream
  import lw_sha_pkg::*;
#(
  parameter int WORD_SIZE = 32
) (
  input  logic                                    clk_i,
  input  logic                                    aresetn_i,
  input  logic [DIGEST_WORDS-1:0][WORD_SIZE-1:0]  hash_i,
  input  logic                                    done_i,
  input  logic [3:0]                              digest_len_i,
  input  logic                                    abort_i,
  input  logic                                    clear_i,
  output logic [WORD_SIZE-1:0]                    dout_o,
  output logic                                    dout_valid_o,
  input  logic                                    dout_ready_i,
  output logic                                    dout_last_o,
  output logic                                    busy_o,
  output logic                                    overrun_o
);

  digest_stream_state_e                   state_q, state_d;
  logic [DIGEST_WORDS-1:0][WORD_SIZE-1:0] buf_q;
  logic [2:0]                             idx_q;
  logic [3:0]                             len_q;
  logic                                   overrun_q;

  logic [3:0] last_idx;
  logic       at_last;
  logic       handshake;
  logic       final_hs;
  logic       capture;
  logic       drop;

  // len_q is 1..8 while streaming, so last_idx never underflows there.
  assign last_idx  = len_q - 4'd1;
  assign at_last   = ({1'b0, idx_q} == last_idx);
  assign handshake = (state_q == STREAM) && dout_ready_i;
  assign final_hs  = handshake && at_last;

  // A new digest is accepted whenever the buffer is free or being freed this
  // cycle: idle, the wipe cycle, or the final handshake (overwrite case).
  assign capture = !abort_i && done_i &&
                   ((state_q == IDLE) || (state_q == ZERO) || final_hs);
  assign drop    = !abort_i && done_i && (state_q == STREAM) && !final_hs;

  always_ff @(posedge clk_i or negedge aresetn_i) begin
    if (!aresetn_i) begin
      state_q   <= IDLE;
      buf_q     <= '0;
      idx_q     <= 3'd0;
      len_q     <= 4'd0;
      overrun_q <= 1'b0;
    end else begin
      state_q <= state_d;

      if (abort_i || (state_q == ZERO && !capture)) begin
        buf_q <= '0;
        idx_q <= 3'd0;
        len_q <= 4'd0;
      end else if (capture) begin
        buf_q <= hash_i;
        idx_q <= 3'd0;
        len_q <= digest_len_clamp(digest_len_i);
      end else if (handshake && !at_last) begin
        idx_q <= idx_q + 3'd1;
      end

      // Set wins over a coincident clear.
      if (drop) begin
        overrun_q <= 1'b1;
      end else if (clear_i) begin
        overrun_q <= 1'b0;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    if (abort_i) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE:    if (done_i) state_d = STREAM;
        STREAM:  if (final_hs) state_d = done_i ? STREAM : ZERO;
        ZERO:    state_d = done_i ? STREAM : IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    dout_valid_o = (state_q == STREAM);
    dout_last_o  = dout_valid_o && at_last;
    dout_o       = dout_valid_o ? buf_q[idx_q] : '0;
    busy_o       = (state_q != IDLE);
    overrun_o    = overrun_q;
  end

endmodule

// File: doc/lw_digest_stream.md
# lw_digest_stream

Downstream output stage for the lightweight SHA/HMAC engine. Captures the eight-word digest array on the engine's `done` pulse and truncates it to the configured digest length. Streams the words out over a valid/ready interface with a `last` marker, then zeroizes its buffer so that no digest material stays resident after it has been consumed or aborted.

## Interface
- `WORD_SIZE`, 32: digest word width; 64 in CORE_ARCH_S64 builds.
- `clk_i`  in  1  clock; all logic on rising edge.
- `aresetn_i`  in  1  reset, asynchronous, active-low.
- `hash_i`  in  WORD_SIZE x 8  digest words from the engine (`hash_i[0]` is sent first).
- `done_i`  in  1  single-cycle pulse; `hash_i` is valid in the same cycle.
- `digest_len_i`  in  4  number of words to emit (1..8), sampled with `done_i`; 0 or >8 is treated as 8.
- `abort_i`  in  1  abort: wipes the buffer and returns to IDLE.
- `clear_i`  in  1  clears sticky `overrun_o`.
- `dout_o`  out  WORD_SIZE  current output word; forced to 0 whenever `dout_valid_o`=0.
- `dout_valid_o`  out  1  output word valid.
- `dout_ready_i`  in  1  consumer accepts the word.
- `dout_last_o`  out  1  marks the final word; only high together with `dout_valid_o`.
- `busy_o`  out  1  high in STREAM and ZERO.
- `overrun_o`  out  1  sticky: a digest arrived while busy and was dropped.

## Operation
- **States.** The block has three states: IDLE, STREAM, ZERO.
- **IDLE.**
  - On `done_i`: load `hash_i[0..7]` into the buffer, latch `len` = clamp(`digest_len_i`), set `idx`=0, go to STREAM.
- **STREAM.**
  - `dout_o` = `buf[idx]`, `dout_valid_o`=1, `dout_last_o` = (`idx`==`len`-1).
  - Handshake is `dout_valid_o && dout_ready_i`. On a non-final handshake, `idx` increments by 1.
  - On the final handshake, go to ZERO.
  - Word and last are held stable while `dout_ready_i`=0.
- **ZERO.**
  - One cycle; the whole buffer, `idx` and `len` are cleared to 0; then go to IDLE.
- **`done_i` while STREAM with no final handshake in that cycle.**
  - The new digest is dropped, `overrun_o` is set, and the current stream continues unaffected.
- **`done_i` in the same cycle as the final handshake.**
  - The new digest is captured, `idx`=0, and the state stays in STREAM. This is the overwrite case: no ZERO cycle and no overrun.
- **`done_i` in ZERO.**
  - The digest is captured and the next state is STREAM, which also overwrites the buffer. No overrun.
- **`abort_i`.**
  - Highest priority in every state: buffer, `idx` and `len` are zeroed and the next state is IDLE.
  - A coincident `done_i` is ignored, and `overrun_o` is not set by it.
- **`clear_i`.** Clears `overrun_o`. If a set condition occurs in the same cycle, the set wins.
- **Counter width.** `idx` is 3 bits and never wraps past `len`-1.

## Timing
- **Reset values.** `dout_o`=0, `dout_valid_o`=0, `dout_last_o`=0, `busy_o`=0, `overrun_o`=0; state IDLE; buffer all-zero.
- **Registered outputs.** All outputs are driven from registers or state only; there is no combinational path from `dout_ready_i` to `dout_valid_o`.
- **Latency.** `done_i` at cycle N → `dout_valid_o`=1 with word 0 at N+1.
- **Throughput.** With `dout_ready_i` held high: 1 word/cycle, so `len` words occupy cycles N+1..N+len.
- **Wipe.** Final handshake at cycle M → ZERO at M+1 (`busy_o`=1, `dout_valid_o`=0) → IDLE at M+2.
- **Abort.** `abort_i` at cycle K → `dout_valid_o`=0 and `busy_o`=0 from K+1.
- **Reset mid-stream.** Immediate: outputs go to their reset values asynchronously, and the buffer is cleared.

## Structure
- In `lw_sha_pkg`:
  - typedef `digest_stream_state_e` {IDLE, STREAM, ZERO}
  - `localparam DIGEST_WORDS = 8`
  - function `digest_len_clamp(logic [3:0])` returning 1..8
- Single flat module; no sub-module is warranted. Buffer, index and FSM all sit in one `always_ff` block, with the output mux in `always_comb`.
- In integration, `hash_o` and `done_o` of the HMAC wrapper connect to `hash_i` and `done_i`. The top-level controller derives `digest_len_i` from the opcode (e.g. 7 for SHA-224 in a 32-bit build, 8 for SHA-256).

## Test plan
- **Basic stream.** `WORD_SIZE`=32, `hash_i[k]`=32'h1000_0000+k, `digest_len_i`=8, ready tied high.
  - Words 0x10000000..0x10000007 appear on cycles N+1..N+8, with last on the 8th only.
  - ZERO at N+9, IDLE at N+10.
- **Truncate and stall.** `digest_len_i`=7, `dout_ready_i` toggling 1,0,0,1,...
  - Exactly 7 words are emitted in order, each held stable during stalls; last on word 6.
  - `hash_i[7]` never appears on `dout_o`.
- **Overrun and overwrite.**
  - Second `done_i` mid-stream → `overrun_o`=1 and the first digest completes intact.
  - `done_i` coincident with the final handshake → new digest word 0 on the next cycle and `overrun_o` unchanged.
  - `clear_i` → `overrun_o`=0.
- **Abort.** `abort_i` after 3 accepted words:
  - `dout_valid_o`=0 the next cycle.
  - Buffer is zero: a following `done_i` with `hash_i`=0 and len 8 emits all zeros, with no residual data.
- **Clamp and reset.**
  - `digest_len_i`=0 and `digest_len_i`=12 each emit 8 words.
  - `aresetn_i` low mid-stream: all outputs are 0 asynchronously and the state is IDLE after release.
